mod_74x163_w: RTL and testbench
===============================

MOD_74X163_W -- requirements
Module: mod_74x163_w

Interface
- REQ-001: Parameter WIDTH, default 4: counter width in bits; legal range 2..16.
- REQ-002: Parameter MODULUS, default 16: count modulus; legal 2..2**WIDTH; default is binary (74x163), 10 gives decade (74x162).
- REQ-003: Single clock, reset synchronous and active-low, all state updates on rising CLK.
- REQ-004: CLK  input  1  clock, rising edge.
- REQ-005: CLR_N  input  1  synchronous clear, active-low.
- REQ-006: LOAD_N  input  1  synchronous parallel load, active-low.
- REQ-007: ENP  input  1  count enable (parallel).
- REQ-008: ENT  input  1  count enable (trickle); also gates RCO.
- REQ-009: D  input  WIDTH  parallel load data.
- REQ-010: Q  output  WIDTH  registered count.
- REQ-011: RCO  output  1  ripple carry out, combinational.
- REQ-012: U_D  input  1  direction (1 = up, 0 = down); present only with MOD_74X163_DOWN_EN.

Function
- REQ-013: Per rising CLK, priority: CLR_N=0 -> Q=0; else LOAD_N=0 -> Q=D, regardless of ENP/ENT; else ENP=1 and ENT=1 -> count one step; else hold.
- REQ-014: Up step: Q>=MODULUS-1 -> 0; otherwise Q+1. A loaded out-of-range value returns to 0 on the next count.
- REQ-015: Down step (macro only): Q==0 or Q>=MODULUS -> MODULUS-1; otherwise Q-1.
- REQ-016: Terminal count TC = (Q==MODULUS-1) when counting up, (Q==0) when counting down.
- REQ-017: RCO = ENT & TC, combinational; ENP does not affect RCO.
- REQ-018: Load and count take effect on the same edge; Q latency is one cycle, RCO latency is zero cycles from Q/ENT/U_D.
- REQ-019: Cascading: RCO of stage n drives ENT of stage n+1 with shared CLK/ENP; the chain forms a MODULUS**k counter with no extra logic.
- REQ-020: U_D change while enabled takes effect on the next edge with no skipped or repeated state.
- REQ-021: All arithmetic wraps within WIDTH bits; no X/Z on Q after the first clocked clear.

Reset
- REQ-022: CLR_N=0 sampled at an edge forces Q=0 and overrides LOAD_N, ENP, ENT, and U_D.
- REQ-023: After reset, RCO=0 in up mode; RCO=ENT in down mode (Q=0 is terminal).
- REQ-024: Clear asserted mid-count or during load aborts that operation; counting resumes from 0 on the first edge with CLR_N=1.

Configuration
- REQ-025: MOD_74X163_DOWN_EN defined: U_D port present; up/down behaviour per REQ-014..016.
- REQ-026: MOD_74X163_DOWN_EN undefined: no U_D port; up-count only; down-count logic absent.

Structure
- REQ-027: Shared package mod_74xx_pkg holds the WIDTH/MODULUS legality bounds and the direction encoding constants (DIR_UP=1, DIR_DN=0).
- REQ-028: One sub-module, mod_74x163_tc: combinational terminal-count detector (Q, U_D, ENT -> TC, RCO), instantiated once.
- REQ-029: Illegal parameter combinations are flagged at elaboration.

Verification
- REQ-030: WIDTH=4, MODULUS=16: CLR_N=0 for 1 edge, then ENP=ENT=1 for 16 edges -> Q runs 0..15,0; RCO=1 only while Q=15.
- REQ-031: MODULUS=10: LOAD_N=0, D=7; then 3 count edges -> Q=8,9,0; RCO=1 at Q=9; load D=12, then 1 count edge -> Q=0.
- REQ-032: Same edge CLR_N=0, LOAD_N=0, D=5 -> Q=0; LOAD_N=0 with ENP=ENT=0, D=5 -> Q=5.
- REQ-033: Q=15, ENP=0, ENT=1 -> Q holds 15, RCO=1; ENT=0 -> RCO=0, Q holds.
- REQ-034: Two WIDTH=4 stages cascaded (RCO->ENT), 256 count edges from 0 -> combined count {Q1,Q0} steps 0x00..0xFF, 0x00; upper stage advances only on lower Q=15.
- REQ-035: With MOD_74X163_DOWN_EN, MODULUS=10, U_D=0, from reset -> Q=9,8,..,0,9; RCO=ENT at Q=0; toggle U_D at Q=4 -> next Q=5.

Source files
------------

// File: rtl/mod_74xx_pkg.sv
// Shared constants for the 74xx-style counter family: parameter legality
// bounds and the direction encoding used on U_D.
package mod_74xx_pkg;

   localparam int WIDTH_MIN   = 2;
   localparam int WIDTH_MAX   = 16;
   localparam int MODULUS_MIN = 2;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   // True when the WIDTH/MODULUS pair describes a buildable counter.
   function automatic bit params_ok(int width, int modulus);
      return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
             (modulus >= MODULUS_MIN) && (modulus <= (1 << width));
   endfunction

endpackage

// File: rtl/mod_74x163_tc.sv
// Combinational terminal-count / ripple-carry detector for mod_74x163_w.
// With MOD_74X163_DOWN_EN the terminal state follows the count direction.
module mod_74x163_tc
   import mod_74xx_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
`ifdef MOD_74X163_DOWN_EN
   input  logic             u_d,
`endif
   input  logic [WIDTH-1:0] q,
   input  logic             ent,
   output logic             tc,
   output logic             rco
);

   localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);

   always_comb begin
`ifdef MOD_74X163_DOWN_EN
      tc = (u_d == DIR_UP) ? (q == TERM) : (q == '0);
`else
      tc = (q == TERM);
`endif
      rco = ent & tc;
   end

endmodule

// File: rtl/mod_74x163_w.sv
// Parameterised synchronous modulo-N counter in the style of the 74x163/162.
// Define MOD_74X163_DOWN_EN to add the U_D port and down counting.
module mod_74x163_w
   import mod_74xx_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic             CLK,
   input  logic             CLR_N,
   input  logic             LOAD_N,
   input  logic             ENP,
   input  logic             ENT,
`ifdef MOD_74X163_DOWN_EN
   input  logic             U_D,
`endif
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             RCO
);

   generate
      if (!params_ok(WIDTH, MODULUS)) begin : g_bad_params
         $error("mod_74x163_w: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
      end
   endgenerate

   localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   logic [WIDTH-1:0] nxt;
   logic             tc;

   // Out-of-range values (only reachable by load) fold back into the ring.
   always_comb begin
      nxt = (32'(Q) >= MODULUS - 1) ? '0 : Q + ONE;
`ifdef MOD_74X163_DOWN_EN
      if (U_D == DIR_DN)
         nxt = (Q == '0 || 32'(Q) >= MODULUS) ? TERM : Q - ONE;
`endif
   end

   always_ff @(posedge CLK) begin
      if (!CLR_N)
         Q <= '0;
      else if (!LOAD_N)
         Q <= D;
      else if (ENP && ENT)
         Q <= nxt;
   end

   mod_74x163_tc #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_tc (
`ifdef MOD_74X163_DOWN_EN
      .u_d (U_D),
`endif
      .q   (Q),
      .ent (ENT),
      .tc  (tc),
      .rco (RCO)
   );

endmodule

// File: tb/tb_mod_74x163_w.sv
// Randomised/directed bench for mod_74x163_w against an arithmetic reference
// model; covers binary, decade, cascaded and odd-modulus instances.
module tb_mod_74x163_w;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   int nvec = 0;
   int nerr = 0;

   // A: binary 4-bit
   logic a_clr, a_load, a_enp, a_ent, a_rco, a_ud;
   logic [3:0] a_d, a_q;
   // B: decade
   logic b_clr, b_load, b_enp, b_ent, b_rco, b_ud;
   logic [3:0] b_d, b_q;
   // C: two cascaded binary stages
   logic c_clr, c_load, c_enp, c_ent, c_rco0, c_rco1, c_ud;
   logic [3:0] c_d, c_q0, c_q1;
   // R: odd modulus, 5 bits
   logic r_clr, r_load, r_enp, r_ent, r_rco, r_ud;
   logic [4:0] r_d, r_q;

   mod_74x163_w #(.WIDTH(4), .MODULUS(16)) dut_a (
      .CLK(CLK), .CLR_N(a_clr), .LOAD_N(a_load), .ENP(a_enp), .ENT(a_ent),
`ifdef MOD_74X163_DOWN_EN
      .U_D(a_ud),
`endif
      .D(a_d), .Q(a_q), .RCO(a_rco));

   mod_74x163_w #(.WIDTH(4), .MODULUS(10)) dut_b (
      .CLK(CLK), .CLR_N(b_clr), .LOAD_N(b_load), .ENP(b_enp), .ENT(b_ent),
`ifdef MOD_74X163_DOWN_EN
      .U_D(b_ud),
`endif
      .D(b_d), .Q(b_q), .RCO(b_rco));

   mod_74x163_w #(.WIDTH(4), .MODULUS(16)) dut_c0 (
      .CLK(CLK), .CLR_N(c_clr), .LOAD_N(c_load), .ENP(c_enp), .ENT(c_ent),
`ifdef MOD_74X163_DOWN_EN
      .U_D(c_ud),
`endif
      .D(c_d), .Q(c_q0), .RCO(c_rco0));

   mod_74x163_w #(.WIDTH(4), .MODULUS(16)) dut_c1 (
      .CLK(CLK), .CLR_N(c_clr), .LOAD_N(c_load), .ENP(c_enp), .ENT(c_rco0),
`ifdef MOD_74X163_DOWN_EN
      .U_D(c_ud),
`endif
      .D(c_d), .Q(c_q1), .RCO(c_rco1));

   mod_74x163_w #(.WIDTH(5), .MODULUS(21)) dut_r (
      .CLK(CLK), .CLR_N(r_clr), .LOAD_N(r_load), .ENP(r_enp), .ENT(r_ent),
`ifdef MOD_74X163_DOWN_EN
      .U_D(r_ud),
`endif
      .D(r_d), .Q(r_q), .RCO(r_rco));

   // Reference: next count from the priority rules in plain integer arithmetic.
   function automatic int ref_next(int q, bit clr_n, bit load_n, int d,
                                   bit enp, bit ent, bit up, int m);
      if (!clr_n) return 0;
      if (!load_n) return d;
      if (!(enp && ent)) return q;
      if (up) return (q >= m - 1) ? 0 : q + 1;
      return (q == 0 || q >= m) ? m - 1 : q - 1;
   endfunction

   function automatic bit ref_rco(int q, bit ent, bit up, int m);
      return ent && (up ? (q == m - 1) : (q == 0));
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      a_clr = 0; a_load = 0; a_enp = 1; a_ent = 1; a_d = 4'd9;
      b_clr = 0; b_load = 0; b_enp = 1; b_ent = 1; b_d = 4'd3;
      c_clr = 0; c_load = 1; c_enp = 1; c_ent = 1; c_d = 4'd0;
      r_clr = 0; r_load = 1; r_enp = 1; r_ent = 1; r_d = 5'd0;
      step();
      nvec++; if (a_q !== 4'd0) begin nerr++; $display("FAIL reset_a_q got %0h want 0", a_q); end
      nvec++; if (b_q !== 4'd0) begin nerr++; $display("FAIL reset_b_q got %0h want 0", b_q); end
      nvec++; if ({c_q1, c_q0} !== 8'h00) begin nerr++; $display("FAIL reset_c_q got %0h want 0", {c_q1, c_q0}); end
      nvec++; if (r_q !== 5'd0) begin nerr++; $display("FAIL reset_r_q got %0h want 0", r_q); end
      nvec++; if (a_rco !== 1'b0) begin nerr++; $display("FAIL reset_a_rco got %b want 0", a_rco); end
      a_clr = 1; a_load = 1; b_clr = 1; b_load = 1; c_clr = 1; r_clr = 1;
   endtask

   task automatic test_count16();
      int m = 0;
      a_clr = 0; step(); a_clr = 1;
      a_enp = 1; a_ent = 1;
      for (int i = 0; i < 16; i++) begin
         m = ref_next(m, 1, 1, 0, 1, 1, 1, 16);
         step();
         nvec++;
         if (a_q !== 4'(m) || a_rco !== ref_rco(m, 1, 1, 16)) begin
            nerr++; $display("FAIL count16 step %0d q=%0d rco=%b want q=%0d rco=%b",
                             i, a_q, a_rco, m, ref_rco(m, 1, 1, 16));
         end
      end
      nvec++; if (a_q !== 4'd0) begin nerr++; $display("FAIL count16_wrap got %0d want 0", a_q); end
   endtask

   task automatic test_decade();
      int exp_q[3] = '{8, 9, 0};
      b_load = 0; b_d = 4'd7; b_enp = 0; b_ent = 0; step();
      nvec++; if (b_q !== 4'd7) begin nerr++; $display("FAIL decade_load got %0d want 7", b_q); end
      b_load = 1; b_enp = 1; b_ent = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         nvec++;
         if (b_q !== 4'(exp_q[i]) || b_rco !== (exp_q[i] == 9)) begin
            nerr++; $display("FAIL decade_count %0d q=%0d rco=%b want q=%0d rco=%b",
                             i, b_q, b_rco, exp_q[i], exp_q[i] == 9);
         end
      end
      b_load = 0; b_d = 4'd12; step();
      nvec++; if (b_q !== 4'd12 || b_rco !== 1'b0) begin nerr++; $display("FAIL decade_load12 q=%0d rco=%b want 12/0", b_q, b_rco); end
      b_load = 1; step();
      nvec++; if (b_q !== 4'd0) begin nerr++; $display("FAIL decade_oor_wrap got %0d want 0", b_q); end
   endtask

   task automatic test_priority();
      a_load = 0; a_d = 4'd3; step();
      a_clr = 0; a_load = 0; a_d = 4'd5; a_enp = 1; a_ent = 1; step();
      nvec++; if (a_q !== 4'd0) begin nerr++; $display("FAIL clr_over_load got %0d want 0", a_q); end
      a_clr = 1; a_load = 0; a_d = 4'd5; a_enp = 0; a_ent = 0; step();
      nvec++; if (a_q !== 4'd5) begin nerr++; $display("FAIL load_no_enable got %0d want 5", a_q); end
      a_d = 4'd11; a_enp = 1; a_ent = 1; step();
      nvec++; if (a_q !== 4'd11) begin nerr++; $display("FAIL load_over_count got %0d want 11", a_q); end
      a_load = 1;
   endtask

   task automatic test_hold();
      a_load = 0; a_d = 4'd15; step();
      a_load = 1; a_enp = 0; a_ent = 1; step();
      nvec++; if (a_q !== 4'd15 || a_rco !== 1'b1) begin nerr++; $display("FAIL hold_enp0 q=%0d rco=%b want 15/1", a_q, a_rco); end
      a_ent = 0; #1;
      nvec++; if (a_rco !== 1'b0) begin nerr++; $display("FAIL rco_gate got %b want 0", a_rco); end
      a_enp = 1; step();
      nvec++; if (a_q !== 4'd15 || a_rco !== 1'b0) begin nerr++; $display("FAIL hold_ent0 q=%0d rco=%b want 15/0", a_q, a_rco); end
   endtask

   task automatic test_cascade();
      c_clr = 0; step(); c_clr = 1; c_enp = 1; c_ent = 1;
      for (int i = 1; i <= 256; i++) begin
         step();
         nvec++;
         if ({c_q1, c_q0} !== 8'(i % 256)) begin
            nerr++; $display("FAIL cascade edge %0d got %02h want %02h", i, {c_q1, c_q0}, 8'(i % 256));
         end
      end
   endtask

   task automatic test_random();
      int m = 0;
      bit up = 1;
      r_clr = 0; step();
      for (int i = 0; i < 300; i++) begin
         r_clr  = ($urandom_range(0, 15) != 0);
         r_load = ($urandom_range(0, 7) != 0);
         r_enp  = ($urandom_range(0, 3) != 0);
         r_ent  = ($urandom_range(0, 3) != 0);
         r_d    = 5'($urandom_range(0, 31));
`ifdef MOD_74X163_DOWN_EN
         r_ud = 1'($urandom_range(0, 1));
         up = r_ud;
`endif
         m = ref_next(m, r_clr, r_load, int'(r_d), r_enp, r_ent, up, 21);
         step();
         nvec++;
         if (r_q !== 5'(m) || r_rco !== ref_rco(m, r_ent, up, 21)) begin
            nerr++; $display("FAIL random %0d q=%0d rco=%b want q=%0d rco=%b",
                             i, r_q, r_rco, m, ref_rco(m, r_ent, up, 21));
         end
      end
   endtask

`ifdef MOD_74X163_DOWN_EN
   task automatic test_down();
      int m = 0;
      b_clr = 0; b_load = 1; b_ud = 0; b_enp = 1; b_ent = 1; step();
      nvec++; if (b_q !== 4'd0 || b_rco !== 1'b1) begin nerr++; $display("FAIL down_reset q=%0d rco=%b want 0/1", b_q, b_rco); end
      b_clr = 1;
      for (int i = 0; i < 16; i++) begin
         m = ref_next(m, 1, 1, 0, 1, 1, 0, 10);
         step();
         nvec++;
         if (b_q !== 4'(m) || b_rco !== ref_rco(m, 1, 0, 10)) begin
            nerr++; $display("FAIL down_count %0d q=%0d rco=%b want q=%0d rco=%b", i, b_q, b_rco, m, ref_rco(m, 1, 0, 10));
         end
      end
      nvec++; if (b_q !== 4'd4) begin nerr++; $display("FAIL down_at4 got %0d want 4", b_q); end
      b_ud = 1; step();
      nvec++; if (b_q !== 4'd5) begin nerr++; $display("FAIL down_toggle got %0d want 5", b_q); end
   endtask
`endif

   initial begin
      a_ud = 1; b_ud = 1; c_ud = 1; r_ud = 1;
      test_reset();
      test_count16();
      test_decade();
      test_priority();
      test_hold();
      test_cascade();
      test_random();
`ifdef MOD_74X163_DOWN_EN
      test_down();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
